elevator_queue_ctrl: RTL and testbench
======================================

# elevator_queue_ctrl

- Registered, parametrised successor to the combinational elevator queue update logic.
- Holds an ordered list of distinct requested floors and accepts one floor request per cycle.
- Detects when the car arrives at a queued floor, removes that entry and runs a door-dwell state machine.
- Sits between the call-button debouncers and the car motion controller.

## Interface
Parameters:
- NUM_LVLS, 4, number of floors; floors encoded 0..NUM_LVLS-1
- DEPTH, 4, queue capacity in entries; must satisfy DEPTH ≥ 1 and DEPTH ≤ NUM_LVLS
- DOOR_CYCLES, 8, dwell length in cycles; must be ≥ 1
- LVL_W, $clog2(NUM_LVLS) (minimum 1), floor field width
- CNT_W, $clog2(DEPTH+1), occupancy width

Ports:
- Clocking: one clock; reset is synchronous and active-high.
- clk  in  1  the single clock
- rst  in  1  synchronous, active-high reset
- pressed_en  in  1  floor request valid this cycle
- pressed_lvl  in  LVL_W  requested floor
- pos_valid  in  1  car is at a floor boundary this cycle
- pos_lvl  in  LVL_W  current car floor
- head_valid  out  1  queue non-empty
- head_lvl  out  LVL_W  oldest queued floor (next target)
- count  out  CNT_W  entries held
- full  out  1  count == DEPTH
- req_drop  out  1  one-cycle pulse: request rejected because the queue was full
- stop_at_pos_lvl  out  1  one-cycle pulse: a queued floor was served
- door_open  out  1  high during dwell
- served_cnt  out  16  floors served (see Configuration)

## Operation
- Storage is an array q[0..DEPTH-1] plus count. Entries q[0..count-1] are valid and in arrival order; q[0] is the head.
- Each cycle, phase 1 (add):
  - A request is accepted when pressed_en=1 and pressed_lvl is not already among the valid entries and count<DEPTH.
  - An accepted request is written to q[count].
  - A duplicate request is silently ignored (no req_drop).
  - A non-duplicate request while full is discarded and pulses req_drop.
  - Out-of-range pressed_lvl (≥ NUM_LVLS) is ignored.
- Phase 2 (serve): operates on the post-add list.
  - Serve happens when pos_valid=1, state=MOVE, and pos_lvl matches some entry.
  - The matching entry is removed and entries above it shift down by one, preserving order.
  - count decrements, stop pulses, and the FSM goes to DOOR.
- A request equal to pos_lvl arriving in the same cycle as a matching pos_valid is added and served in that cycle. Net count change is 0 and stop pulses.
- FSM states:
  - IDLE: count==0. → MOVE when the post-add count > 0.
  - MOVE: car travelling. → DOOR on serve.
  - DOOR: dwell timer loads DOOR_CYCLES-1 on entry and decrements each cycle; pos_valid is ignored (no serve). Requests are still accepted. On timer==0: → MOVE if count>0, else → IDLE.
- Reset: queue cleared, count=0, state=IDLE, timer=0, served_cnt=0. Every output is 0 in the cycle after rst is sampled.
- rst asserted mid-dwell or mid-update aborts immediately; the same-cycle request is lost.

## Timing
- All outputs are registered.
- An update takes effect at the clk edge that samples the inputs:
  - head/count/full reflect it in the following cycle.
  - stop_at_pos_lvl and req_drop pulse for exactly that following cycle.
- door_open rises in the cycle after the serve and stays high exactly DOOR_CYCLES cycles.
- Throughput: one request and one serve evaluated per cycle; no backpressure.

## Configuration
- Macro: ELEVATOR_QUEUE_SERVED_CNT_EN.
- Defined: served_cnt is a 16-bit counter that increments on each stop pulse, wraps 0xFFFF→0, and is cleared by rst.
- Undefined: served_cnt is tied to 0 and no counter flops are built. Port list is unchanged.

## Structure
- Shared package elevator_pkg holds:
  - FSM enum (IDLE, MOVE, DOOR)
  - default NUM_LVLS / DEPTH / DOOR_CYCLES constants
  - a function computing LVL_W with a minimum of 1
- One sub-module, queue_compact:
  - combinational: takes the post-add list, count and pos_lvl
  - returns the compacted list, new count and a hit flag
  - instantiated once inside elevator_queue_ctrl

## Test plan
- Reset, then requests 2, 0, 3 on consecutive cycles → head_lvl=2, count=3; a duplicate request 0 leaves count=3 with no req_drop.
- DEPTH=4 filled with 0,1,2,3, then a fifth, non-duplicate request under an override NUM_LVLS=8, DEPTH=4 → req_drop pulses 1 cycle and count stays 4.
- Queue {1,3}, pos_valid with pos_lvl=3 → next cycle stop=1, head_lvl=1, count=1; door_open high 8 cycles, then the FSM returns to MOVE.
- During DOOR, pos_valid with pos_lvl=1 → no serve, count unchanged, no stop pulse.
- Empty queue, request 2 together with pos_valid and pos_lvl=2 → stop pulses, count=0, FSM in DOOR then IDLE.
- rst asserted in the middle of a dwell → next cycle all outputs 0, state IDLE; repeat with ELEVATOR_QUEUE_SERVED_CNT_EN defined and check served_cnt counts serves and resets to 0.

Source files
------------

// File: rtl/elevator_pkg.sv
// Shared constants, FSM state codes and width helper for the elevator queue controller.
package elevator_pkg;

    localparam int unsigned DefNumLvls    = 4;
    localparam int unsigned DefDepth      = 4;
    localparam int unsigned DefDoorCycles = 8;

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StMove = 2'd1;
    localparam logic [1:0] StDoor = 2'd2;

    // Field width able to hold 0..n-1, never narrower than one bit.
    function automatic int unsigned lvl_w_of(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/queue_compact.sv
// Combinational removal of the entry matching pos_lvl from an ordered floor list,
// shifting younger entries down so arrival order is preserved.
module queue_compact #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned LVL_W = 2,
    parameter int unsigned CNT_W = 3
) (
    input  logic [DEPTH-1:0][LVL_W-1:0] list_in,
    input  logic [CNT_W-1:0]            count_in,
    input  logic [LVL_W-1:0]            pos_lvl,
    output logic [DEPTH-1:0][LVL_W-1:0] list_out,
    output logic [CNT_W-1:0]            count_out,
    output logic                        hit
);
    logic [DEPTH-1:0][LVL_W-1:0] shifted;
    logic [CNT_W-1:0]            idx;

    assign shifted = list_in >> LVL_W;

    always_comb begin
        hit = 1'b0;
        idx = '0;
        // Entries are distinct, so at most one valid slot can match.
        for (int i = 0; i < DEPTH; i++) begin
            if (!hit && (CNT_W'(i) < count_in) && (list_in[i] == pos_lvl)) begin
                hit = 1'b1;
                idx = CNT_W'(i);
            end
        end
        list_out = list_in;
        for (int i = 0; i < DEPTH; i++) begin
            if (hit && (CNT_W'(i) >= idx)) list_out[i] = shifted[i];
        end
        count_out = hit ? (count_in - CNT_W'(1)) : count_in;
    end

endmodule

// File: rtl/elevator_queue_ctrl.sv
// Registered elevator request queue with serve detection and door-dwell FSM.
// Define ELEVATOR_QUEUE_SERVED_CNT_EN to build the 16-bit served-floor counter.
module elevator_queue_ctrl
    import elevator_pkg::*;
#(
    parameter int unsigned NUM_LVLS    = DefNumLvls,
    parameter int unsigned DEPTH       = DefDepth,
    parameter int unsigned DOOR_CYCLES = DefDoorCycles,
    parameter int unsigned LVL_W       = lvl_w_of(NUM_LVLS),
    parameter int unsigned CNT_W       = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pressed_en,
    input  logic [LVL_W-1:0] pressed_lvl,
    input  logic             pos_valid,
    input  logic [LVL_W-1:0] pos_lvl,
    output logic             head_valid,
    output logic [LVL_W-1:0] head_lvl,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             req_drop,
    output logic             stop_at_pos_lvl,
    output logic             door_open,
    output logic [15:0]      served_cnt
);
    localparam int unsigned      TMR_W     = lvl_w_of(DOOR_CYCLES);
    localparam logic [TMR_W-1:0] DwellLoad = TMR_W'(DOOR_CYCLES - 1);
    localparam logic [CNT_W-1:0] DepthC    = CNT_W'(DEPTH);
    localparam logic [LVL_W:0]   NumLvlsC  = (LVL_W + 1)'(NUM_LVLS);

    logic [DEPTH-1:0][LVL_W-1:0] q_q, list_add, list_cmp, list_d;
    logic [CNT_W-1:0]            count_q, count_add, count_cmp, count_d;
    logic [1:0]                  state_q, state_d;
    logic [TMR_W-1:0]            timer_q, timer_d;
    logic                        in_range, dup, accept, drop, hit, serve;

    // Phase 1: append a fresh, in-range request if there is room.
    always_comb begin
        in_range = {1'b0, pressed_lvl} < NumLvlsC;
        dup      = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if ((CNT_W'(i) < count_q) && (q_q[i] == pressed_lvl)) dup = 1'b1;
        end
        accept   = pressed_en && in_range && !dup && (count_q != DepthC);
        drop     = pressed_en && in_range && !dup && (count_q == DepthC);
        list_add = q_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (accept && (CNT_W'(i) == count_q)) list_add[i] = pressed_lvl;
        end
        count_add = count_q + CNT_W'(accept);
    end

    queue_compact #(
        .DEPTH (DEPTH),
        .LVL_W (LVL_W),
        .CNT_W (CNT_W)
    ) u_compact (
        .list_in   (list_add),
        .count_in  (count_add),
        .pos_lvl   (pos_lvl),
        .list_out  (list_cmp),
        .count_out (count_cmp),
        .hit       (hit)
    );

    // Phase 2: serving is blocked only while the door dwells. In IDLE the list can
    // only hold the same-cycle request, which is served straight away.
    always_comb begin
        serve   = pos_valid && (state_q != StDoor) && hit;
        list_d  = serve ? list_cmp : list_add;
        count_d = serve ? count_cmp : count_add;
        state_d = state_q;
        timer_d = timer_q;
        if (serve) begin
            state_d = StDoor;
            timer_d = DwellLoad;
        end else begin
            case (state_q)
                StIdle: if (count_d != '0) state_d = StMove;
                StDoor: begin
                    if (timer_q == '0) state_d = (count_d != '0) ? StMove : StIdle;
                    else               timer_d = timer_q - TMR_W'(1);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q             <= '0;
            count_q         <= '0;
            state_q         <= StIdle;
            timer_q         <= '0;
            head_valid      <= 1'b0;
            head_lvl        <= '0;
            full            <= 1'b0;
            req_drop        <= 1'b0;
            stop_at_pos_lvl <= 1'b0;
            door_open       <= 1'b0;
        end else begin
            q_q             <= list_d;
            count_q         <= count_d;
            state_q         <= state_d;
            timer_q         <= timer_d;
            head_valid      <= (count_d != '0);
            head_lvl        <= (count_d != '0) ? list_d[0] : '0;
            full            <= (count_d == DepthC);
            req_drop        <= drop;
            stop_at_pos_lvl <= serve;
            door_open       <= (state_d == StDoor);
        end
    end

    assign count = count_q;

`ifdef ELEVATOR_QUEUE_SERVED_CNT_EN
    logic [15:0] served_q;

    always_ff @(posedge clk) begin
        if (rst)        served_q <= '0;
        else if (serve) served_q <= served_q + 16'd1;
    end

    assign served_cnt = served_q;
`else
    assign served_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_elevator_queue_ctrl.sv
// Bench for elevator_queue_ctrl: directed scenarios plus random traffic against a queue model.
module tb_elevator_queue_ctrl;
    localparam int NL = 8;
    localparam int DP = 4;
    localparam int DC = 8;

    logic        clk = 1'b0;
    logic        rst, pressed_en, pos_valid;
    logic [2:0]  pressed_lvl, pos_lvl;
    logic        head_valid, full, req_drop, stop_at_pos_lvl, door_open;
    logic [2:0]  head_lvl;
    logic [2:0]  count;
    logic [15:0] served_cnt;

    int total = 0;
    int bad   = 0;

    // Reference model: floors in arrival order, mode 0=idle 1=move 2=door.
    int          m_q[$];
    int          m_mode;
    int          m_dwell;
    bit          m_stop, m_drop;
    logic [15:0] m_served;

    elevator_queue_ctrl #(
        .NUM_LVLS    (NL),
        .DEPTH       (DP),
        .DOOR_CYCLES (DC)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .pressed_en      (pressed_en),
        .pressed_lvl     (pressed_lvl),
        .pos_valid       (pos_valid),
        .pos_lvl         (pos_lvl),
        .head_valid      (head_valid),
        .head_lvl        (head_lvl),
        .count           (count),
        .full            (full),
        .req_drop        (req_drop),
        .stop_at_pos_lvl (stop_at_pos_lvl),
        .door_open       (door_open),
        .served_cnt      (served_cnt)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_q.delete();
        m_mode   = 0;
        m_dwell  = 0;
        m_stop   = 0;
        m_drop   = 0;
        m_served = 16'd0;
    endtask

    task automatic model_step(input bit pen, input int plvl, input bit pv, input int plv);
        int k;
        bit seen;
        m_stop = 0;
        m_drop = 0;
        if (pen && plvl < NL) begin
            seen = 0;
            foreach (m_q[i]) if (m_q[i] == plvl) seen = 1;
            if (!seen) begin
                if (m_q.size() < DP) m_q.push_back(plvl);
                else m_drop = 1;
            end
        end
        k = -1;
        if (pv && m_mode != 2) foreach (m_q[i]) if (m_q[i] == plv) k = i;
        if (k >= 0) begin
            m_q.delete(k);
            m_stop   = 1;
            m_mode   = 2;
            m_dwell  = DC;
            m_served = m_served + 16'd1;
        end else if (m_mode == 0) begin
            if (m_q.size() > 0) m_mode = 1;
        end else if (m_mode == 2) begin
            m_dwell--;
            if (m_dwell == 0) m_mode = (m_q.size() > 0) ? 1 : 0;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        int          sz;
        logic [15:0] exp_srv;
        sz = m_q.size();
`ifdef ELEVATOR_QUEUE_SERVED_CNT_EN
        exp_srv = m_served;
`else
        exp_srv = 16'd0;
`endif
        chk({tag, ".head_valid"}, 32'(head_valid), 32'(sz > 0));
        chk({tag, ".head_lvl"}, 32'(head_lvl), (sz > 0) ? 32'(m_q[0]) : 32'd0);
        chk({tag, ".count"}, 32'(count), 32'(sz));
        chk({tag, ".full"}, 32'(full), 32'(sz == DP));
        chk({tag, ".req_drop"}, 32'(req_drop), 32'(m_drop));
        chk({tag, ".stop"}, 32'(stop_at_pos_lvl), 32'(m_stop));
        chk({tag, ".door_open"}, 32'(door_open), 32'(m_mode == 2));
        chk({tag, ".served_cnt"}, 32'(served_cnt), 32'(exp_srv));
    endtask

    // Drive one cycle of inputs, advance model on the edge, check just after it.
    task automatic step(input bit r, input bit pen, input int plvl, input bit pv, input int plv,
                        input string tag);
        rst         = r;
        pressed_en  = pen;
        pressed_lvl = 3'(plvl);
        pos_valid   = pv;
        pos_lvl     = 3'(plv);
        @(posedge clk);
        if (r) model_reset();
        else   model_step(pen, plvl, pv, plv);
        #1;
        check_all(tag);
    endtask

    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, tag);
    endtask

    initial begin
        int  plv;
        bit  r, pen, pv;
        model_reset();

        step(1, 0, 0, 0, 0, "reset");

        // Ordering and duplicate suppression.
        step(0, 1, 2, 0, 0, "add2");
        step(0, 1, 0, 0, 0, "add0");
        step(0, 1, 3, 0, 0, "add3");
        step(0, 1, 0, 0, 0, "dup0");

        // Fill to capacity then overflow with a fresh floor.
        step(1, 0, 0, 0, 0, "reset2");
        for (int f = 0; f < 4; f++) step(0, 1, f, 0, 0, "fill");
        step(0, 1, 5, 0, 0, "overflow");
        idle(1, "after_overflow");

        // Serve out of order, dwell, ignored pos_valid during dwell, then serve again.
        step(1, 0, 0, 0, 0, "reset3");
        step(0, 1, 1, 0, 0, "q1");
        step(0, 1, 3, 0, 0, "q3");
        step(0, 0, 0, 1, 3, "serve3");
        step(0, 0, 0, 1, 1, "door_ignore");
        idle(DC, "dwell");
        step(0, 0, 0, 1, 1, "serve1_after_dwell");

        // Same-cycle add and serve from an empty queue.
        step(1, 0, 0, 0, 0, "reset4");
        step(0, 1, 2, 1, 2, "add_serve");
        idle(DC + 2, "dwell_to_idle");

        // Reset mid-dwell with a request pending in the same cycle.
        step(0, 1, 4, 0, 0, "q4");
        step(0, 1, 6, 1, 4, "serve4");
        idle(3, "mid_dwell");
        step(1, 1, 7, 1, 6, "reset_mid_dwell");
        idle(1, "post_reset");

        // Random traffic with occasional reset.
        for (int n = 0; n < 800; n++) begin
            r   = ($urandom_range(0, 63) == 0);
            pen = ($urandom_range(0, 3) != 0);
            pv  = ($urandom_range(0, 2) == 0);
            if (m_q.size() > 0 && $urandom_range(0, 1) == 1)
                plv = m_q[$urandom_range(0, m_q.size() - 1)];
            else
                plv = $urandom_range(0, NL - 1);
            step(r, pen, $urandom_range(0, NL - 1), pv, plv, "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
